key_decoder_multi: RTL

Parametrised PS/2 key-state decoder for the keyboard path. It tracks the held state of a configurable table of make codes and emits one-cycle press and release strobes, plus a long-press flag and optional auto-repeat strobes per key. It sits between the PS/2 receiver, which supplies the 16-bit keycode history and a byte-valid strobe, and the game and control logic. It replaces single-key decoders such as the one for the space-bar reset.

---
 rtl/key_pkg.sv | 18 +
 rtl/key_channel.sv | 102 ++++++++++
 rtl/key_decoder_multi.sv | 68 ++++++
 3 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - PS/2 prefix bytes, named make codes and key FSM state type
package key_pkg;

    localparam logic [7:0] KEY_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] KEY_EXT_PREFIX   = 8'hE0;

    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;

    typedef enum logic {
        KEY_UP   = 1'b0,
        KEY_DOWN = 1'b1
    } key_state_t;

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key's up/down FSM, hold counter and optional repeat counter
// Optional auto-repeat strobe built only when KEY_REPEAT_EN is defined.
module key_channel
    import key_pkg::*;
#(
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic make_hit,
    input  logic break_hit,
    output logic key_held,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int CW = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);

    key_state_t    state;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= KEY_UP;
            count       <= '0;
            key_held    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                KEY_UP: begin
                    count    <= '0;
                    key_long <= 1'b0;
                    if (make_hit) begin
                        state     <= KEY_DOWN;
                        key_held  <= 1'b1;
                        key_press <= 1'b1;
                    end
                end
                KEY_DOWN: begin
                    if (break_hit) begin
                        state       <= KEY_UP;
                        key_held    <= 1'b0;
                        key_release <= 1'b1;
                        count       <= '0;
                        key_long    <= 1'b0;
                    end else if (count != LONG_MAX) begin
                        // a repeated make while down leaves the counter running untouched
                        count    <= count + CW'(1);
                        key_long <= (count + CW'(1)) == LONG_MAX;
                    end else begin
                        key_long <= 1'b1;
                    end
                end
                default: state <= KEY_UP;
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic          long_rise;

    // true in the cycle whose clock edge will raise key_long
    assign long_rise = (state == KEY_DOWN) && !break_hit && (count == LONG_MAX - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt    <= '0;
            key_repeat <= 1'b0;
        end else begin
            key_repeat <= 1'b0;
            if (long_rise) begin
                key_repeat <= 1'b1;
                rep_cnt    <= '0;
            end else if (key_long && !break_hit) begin
                if (rep_cnt == REP_LAST) begin
                    key_repeat <= 1'b1;
                    rep_cnt    <= '0;
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end else begin
                rep_cnt <= '0;
            end
        end
    end
`else
    assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_decoder_multi.sv
// rtl/key_decoder_multi.sv - multi-key PS/2 make/break decoder with held, strobe and long-press outputs
// Auto-repeat strobes are enabled by defining KEY_REPEAT_EN.
module key_decoder_multi
    import key_pkg::*;
#(
    parameter int                      NUM_KEYS      = 4,
    parameter logic [8*NUM_KEYS-1:0]   KEY_CODES     = {KEY_S, KEY_A, KEY_W, KEY_SPACE},
    parameter int                      LONG_CYCLES   = 1000,
    parameter int                      REPEAT_CYCLES = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         keycode,
    input  logic                keycode_valid,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                any_held
);

    logic                is_break;
    logic [NUM_KEYS-1:0] code_hit;
    logic [NUM_KEYS-1:0] make_hit;
    logic [NUM_KEYS-1:0] break_hit;
    logic [NUM_KEYS-1:0] held_next;

    // an E0 prefix lands in [15:8] and simply reads as "not a break"
    assign is_break = keycode[15:8] == KEY_BREAK_PREFIX;

    genvar i;
    generate
        for (i = 0; i < NUM_KEYS; i++) begin : g_key
            assign code_hit[i]  = keycode_valid && (KEY_CODES[8*i +: 8] != 8'h00)
                                  && (keycode[7:0] == KEY_CODES[8*i +: 8]);
            assign make_hit[i]  = code_hit[i] && !is_break;
            assign break_hit[i] = code_hit[i] && is_break;

            key_channel #(
                .LONG_CYCLES   (LONG_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES)
            ) u_channel (
                .clk         (clk),
                .rst         (rst),
                .make_hit    (make_hit[i]),
                .break_hit   (break_hit[i]),
                .key_held    (key_held[i]),
                .key_press   (key_press[i]),
                .key_release (key_release[i]),
                .key_long    (key_long[i]),
                .key_repeat  (key_repeat[i])
            );
        end
    endgenerate

    // mirrors each channel's next held state so any_held lines up with key_held
    assign held_next = (key_held & ~break_hit) | make_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_held <= 1'b0;
        end else begin
            any_held <= |held_next;
        end
    end

endmodule
